// File: rtl/pkwars_pkg.sv
// Shared definitions for the PK Wars BG VRAM arbiter.
//   - slot numbering: slot SLOT_VID of every pixel period belongs to video,
//     the remaining NSLOT-1 slots belong to the CPU
//   - CPU access FSM encoding, also exported on the arbiter debug port
package pkwars_pkg;

    localparam int         NSLOT    = 4;
    localparam logic [1:0] SLOT_VID = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RDAT = 2'd2,
        ST_DONE = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/pkwars_slot_ctr.sv
// Slot counter for the VRAM time-slot arbiter.
// Ports:
//   clk      in   VCLKx4 system clock
//   rst_n    in   asynchronous active-low reset
//   vclk_en  in   pixel strobe; the cycle it is high is forced to slot 0
//   slot_eff out  slot in effect this cycle (combinational)
// The counter free-runs when no strobe arrives, so video keeps its slot even
// if the strobe is missing; an early strobe resyncs immediately.
module pkwars_slot_ctr
    import pkwars_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vclk_en,
    output logic [1:0] slot_eff
);

    logic [1:0] slot_q;

    assign slot_eff = vclk_en ? SLOT_VID : slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_VID;
        end else if (slot_eff == 2'(NSLOT - 1)) begin
            slot_q <= SLOT_VID;
        end else begin
            slot_q <= slot_eff + 2'd1;
        end
    end

endmodule

// File: rtl/pkwars_vram_arb.sv
// Time-slot arbiter sharing one single-port BG VRAM between the BG scanline
// fetch (slot 0 of every pixel period) and the Z80 (slots 1-3).
// Ports:
//   VCLKx4, RESET_N        clock (4x pixel clock), async active-low reset
//   VCLK_EN                pixel strobe, marks slot 0
//   VID_AD / VID_DT        BG fetch address in, registered fetch data out
//   CPU_REQ/WE/AD/WD       CPU request level, direction, byte address, data
//   CPU_RD/WAIT/ACK        CPU read byte, wait-state, 1-cycle completion pulse
//   RAM_AD/WE/BE/WD/RD     VRAM macro port (read data one cycle after address)
//   DBG_STATE              current CPU FSM state
// CPU handshake: CPU_REQ is a level held by the CPU; the arbiter raises
// CPU_WAIT in the cycle the request is seen and keeps it high until the DONE
// cycle, where CPU_WAIT drops and CPU_ACK pulses for exactly one cycle with
// CPU_RD valid. REQ changes after acceptance are ignored; a REQ still high in
// the cycle after DONE is a new request.
module pkwars_vram_arb
    import pkwars_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          VCLKx4,
    input  logic          RESET_N,
    input  logic          VCLK_EN,
    input  logic [AW-1:0] VID_AD,
    output logic [DW-1:0] VID_DT,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW:0]   CPU_AD,
    input  logic [7:0]    CPU_WD,
    output logic [7:0]    CPU_RD,
    output logic          CPU_WAIT,
    output logic          CPU_ACK,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [DW/8-1:0] RAM_BE,
    output logic [DW-1:0] RAM_WD,
    input  logic [DW-1:0] RAM_RD,
    output cpu_state_e    DBG_STATE
);

    localparam int NB = DW / 8;

    cpu_state_e    state_q, state_d;
    logic [1:0]    slot_eff;
    logic          is_vid;
    logic          lat_we;
    logic [AW:0]   lat_ad;
    logic [7:0]    lat_wd;
    logic          accept, issue, use_lat;
    logic          iss_we;
    logic [AW:0]   iss_ad;
    logic [7:0]    iss_wd;
    logic [AW-1:0] ram_ad_q;
    logic          vid_cap;

    pkwars_slot_ctr u_slot (
        .clk      (VCLKx4),
        .rst_n    (RESET_N),
        .vclk_en  (VCLK_EN),
        .slot_eff (slot_eff)
    );

    assign is_vid    = (slot_eff == SLOT_VID);
    assign DBG_STATE = state_q;

    // Next state. PEND waits for a non-video slot rather than assuming the
    // next cycle is slot 1, so an early strobe just delays the issue.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        use_lat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CPU_REQ) begin
                    accept = 1'b1;
                    if (is_vid) begin
                        state_d = ST_PEND;
                    end else begin
                        issue   = 1'b1;
                        state_d = CPU_WE ? ST_DONE : ST_RDAT;
                    end
                end
            end
            ST_PEND: begin
                if (!is_vid) begin
                    issue   = 1'b1;
                    use_lat = 1'b1;
                    state_d = lat_we ? ST_DONE : ST_RDAT;
                end
            end
            ST_RDAT: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue fields: live from the CPU in IDLE, latched copies from PEND.
    always_comb begin
        iss_we = use_lat ? lat_we : CPU_WE;
        iss_ad = use_lat ? lat_ad : CPU_AD;
        iss_wd = use_lat ? lat_wd : CPU_WD;
    end

    // VRAM port mux. Gated by reset so every output reads 0 while held.
    always_comb begin
        RAM_AD = ram_ad_q;
        RAM_WE = 1'b0;
        RAM_BE = '0;
        RAM_WD = '0;
        if (RESET_N) begin
            if (is_vid) begin
                RAM_AD = VID_AD;
                RAM_BE = '1;
            end else if (issue) begin
                RAM_AD            = iss_ad[AW:1];
                RAM_WE            = iss_we;
                RAM_BE[iss_ad[0]] = 1'b1;
                RAM_WD            = {NB{iss_wd}};
            end
        end
    end

    assign CPU_WAIT = RESET_N & (((state_q == ST_IDLE) & CPU_REQ) |
                                 (state_q == ST_PEND) | (state_q == ST_RDAT));
    assign CPU_ACK  = (state_q == ST_DONE);

    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            lat_we   <= 1'b0;
            lat_ad   <= '0;
            lat_wd   <= '0;
            VID_DT   <= '0;
            CPU_RD   <= '0;
            ram_ad_q <= '0;
            vid_cap  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_ad_q <= RAM_AD;
            vid_cap  <= is_vid;
            if (accept) begin
                lat_we <= CPU_WE;
                lat_ad <= CPU_AD;
                lat_wd <= CPU_WD;
            end
            // RAM_RD belongs to the address presented in the previous cycle.
            if (vid_cap) begin
                VID_DT <= RAM_RD;
            end
            if (state_q == ST_RDAT) begin
                CPU_RD <= RAM_RD[{lat_ad[0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_pkwars_vram_arb.sv
module tb_pkwars_vram_arb;
    import pkwars_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        VCLKx4 = 1'b0;
    logic        RESET_N;
    logic        VCLK_EN;
    logic [9:0]  VID_AD;
    logic [15:0] VID_DT;
    logic        CPU_REQ, CPU_WE;
    logic [10:0] CPU_AD;
    logic [7:0]  CPU_WD, CPU_RD;
    logic        CPU_WAIT, CPU_ACK;
    logic [9:0]  RAM_AD;
    logic        RAM_WE;
    logic [1:0]  RAM_BE;
    logic [15:0] RAM_WD, RAM_RD;
    cpu_state_e  dbg_state;

    always #5 VCLKx4 = ~VCLKx4;

    pkwars_vram_arb dut (
        .VCLKx4(VCLKx4), .RESET_N(RESET_N), .VCLK_EN(VCLK_EN),
        .VID_AD(VID_AD), .VID_DT(VID_DT),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_AD(CPU_AD), .CPU_WD(CPU_WD),
        .CPU_RD(CPU_RD), .CPU_WAIT(CPU_WAIT), .CPU_ACK(CPU_ACK),
        .RAM_AD(RAM_AD), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE), .RAM_WD(RAM_WD),
        .RAM_RD(RAM_RD), .DBG_STATE(dbg_state)
    );

    // ---------------- VRAM macro model ----------------
    logic [15:0] mem [0:1023];
    logic [9:0]  ram_aq = '0;
    logic        init_v = 1'b0, poke_v = 1'b0;
    logic [9:0]  poke_a = '0;
    logic [15:0] poke_d = '0;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503) ^ 16'h5A3C;
    endfunction

    always @(posedge VCLKx4) begin
        if (init_v) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (poke_v) begin
            mem[poke_a] <= poke_d;
        end else if (RAM_WE) begin
            if (RAM_BE[0]) mem[RAM_AD][7:0]  <= RAM_WD[7:0];
            if (RAM_BE[1]) mem[RAM_AD][15:8] <= RAM_WD[15:8];
        end
        ram_aq <= RAM_AD;
    end
    assign RAM_RD = mem[ram_aq];

    // ---------------- reference state / scoreboard ----------------
    logic [15:0] ref_mem [0:1023];
    // entry: [47:32] ack cycle, [31] we, [30:20] byte addr, [19:12] wd, [7:0] read byte
    logic [47:0] exp_q[$];
    int          vh_cyc[$];
    logic [15:0] vh_val[$];
    logic [15:0] vid_exp = '0;
    int  checks = 0, failures = 0;
    int  cyc = 0, nxt_slot = 0, cs = 0, we_count = 0;
    bit  periodic = 1'b1, early_en = 1'b0, rand_vid = 1'b0;
    logic [47:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge VCLKx4) begin
        if (!RESET_N) begin
            exp_q.delete();
            vh_cyc.delete();
            vh_val.delete();
            vid_exp  = '0;
            nxt_slot = 0;
        end else begin
            cs = VCLK_EN ? 0 : nxt_slot;
            if (cs == 0) begin
                check("vid_ram_ad", 32'(RAM_AD), 32'(VID_AD));
                check("vid_ram_we", 32'(RAM_WE), 32'd0);
                check("vid_ram_be", 32'(RAM_BE), 32'd3);
                vh_cyc.push_back(cyc + 2);
                vh_val.push_back(ref_mem[VID_AD]);
            end
            while (vh_cyc.size() > 0 && vh_cyc[0] <= cyc) begin
                vid_exp = vh_val[0];
                void'(vh_cyc.pop_front());
                void'(vh_val.pop_front());
            end
            check("vid_dt", 32'(VID_DT), 32'(vid_exp));
            if (RAM_WE) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    check("ram_we_unexpected", 32'(RAM_WE), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("wr_is_write", 32'(RAM_WE), 32'(e[31]));
                    check("wr_ram_ad", 32'(RAM_AD), 32'(e[30:21]));
                    check("wr_ram_be", 32'(RAM_BE), e[20] ? 32'd2 : 32'd1);
                    check("wr_ram_wd", 32'(RAM_WD), 32'({e[19:12], e[19:12]}));
                end
            end
            if (CPU_ACK) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'(CPU_ACK), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(e[47:32]));
                    check("wait_in_done", 32'(CPU_WAIT), 32'd0);
                    if (!e[31]) check("cpu_rd", 32'(CPU_RD), 32'(e[7:0]));
                end
            end else if (exp_q.size() > 0) begin
                check("cpu_wait_busy", 32'(CPU_WAIT), 32'd1);
            end else if (!CPU_REQ) begin
                check("cpu_wait_idle", 32'(CPU_WAIT), 32'd0);
            end
            nxt_slot = (cs + 1) % NSLOT;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge VCLKx4);
        #1;
        cyc++;
        VCLK_EN  = (periodic && (cyc % 4 == 0)) || early_en;
        early_en = 1'b0;
        poke_v   = 1'b0;
        init_v   = 1'b0;
        if (rand_vid) VID_AD = 10'h300 | 10'($urandom_range(0, 255));
    endtask

    function automatic int slot_now();
        return VCLK_EN ? 0 : nxt_slot;
    endfunction

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8 && slot_now() != s; i++) step();
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        poke_a = a; poke_d = d; poke_v = 1'b1;
        ref_mem[a] = d;
        step();
    endtask

    // Presents one CPU access in the current cycle and follows it to ACK.
    task automatic cpu_access(input bit we, input logic [10:0] ad, input logic [7:0] wd,
                              input bit hold, input bit drop, input bit early);
        int s, lat, wc0;
        bit done;
        logic [15:0] w;
        logic [7:0]  rd;
        s   = slot_now();
        wc0 = we_count;
        lat = (we ? 1 : 2) + ((s == 0) ? 1 : 0) + (early ? 1 : 0);
        w   = ref_mem[ad[10:1]];
        rd  = ad[0] ? w[15:8] : w[7:0];
        if (we) begin
            if (ad[0]) w[15:8] = wd; else w[7:0] = wd;
            ref_mem[ad[10:1]] = w;
        end
        exp_q.push_back({16'(cyc + lat), we, ad, wd, 4'h0, rd});
        CPU_REQ = 1'b1; CPU_WE = we; CPU_AD = ad; CPU_WD = wd;
        done = 1'b0;
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge VCLKx4);
            if (CPU_ACK) begin
                done = 1'b1;
            end else begin
                if (early && n == 0) early_en = 1'b1;
                step();
                if (drop && n == 0) begin
                    CPU_REQ = 1'b0;
                    CPU_WE  = ~we;
                    CPU_AD  = 11'($urandom_range(0, 2047));
                    CPU_WD  = 8'($urandom_range(0, 255));
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ACK expected ACK within 16 cycles (cycle %0d)", cyc);
            exp_q.delete();
        end else begin
            check("we_pulses", 32'(we_count - wc0), we ? 32'd1 : 32'd0);
        end
        step();
        if (!hold) begin
            CPU_REQ = 1'b0;
            CPU_WE  = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET_N = 1'b0; VCLK_EN = 1'b0; VID_AD = '0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_AD = '0; CPU_WD = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        init_v = 1'b1;
        step();

        // reset state, with a request pending to exercise output gating
        CPU_REQ = 1'b1;
        #1;
        check("rst_vid_dt", 32'(VID_DT), 32'd0);
        check("rst_cpu_wait", 32'(CPU_WAIT), 32'd0);
        check("rst_ram_be", 32'(RAM_BE), 32'd0);
        check("rst_ram_ad", 32'(RAM_AD), 32'd0);
        CPU_REQ = 1'b0;
        poke(10'h155, 16'hA5C3);
        step();

        // test 1: video only
        VID_AD  = 10'h155;
        RESET_N = 1'b1;
        repeat (16) step();
        #1;
        check("t1_vid_dt", 32'(VID_DT), 32'hA5C3);

        // test 2: CPU write in slot 1 to the word video is fetching
        wait_slot(1);
        cpu_access(1'b1, 11'h2AB, 8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (8) step();
        #1;
        check("t2_vid_after_wr", 32'(VID_DT), 32'h7EC3);

        // test 3: CPU read requested in slot 0
        poke(10'h155, 16'h1234);
        wait_slot(0);
        cpu_access(1'b0, 11'h2AA, 8'h00, 1'b0, 1'b0, 1'b0);

        // test 4: back-to-back with REQ held through DONE
        repeat (2) step();
        wait_slot(2);
        cpu_access(1'b0, 11'h123, 8'h00, 1'b1, 1'b0, 1'b0);
        cpu_access(1'b1, 11'h124, 8'h9B, 1'b0, 1'b0, 1'b0);
        cpu_access(1'b0, 11'h124, 8'h00, 1'b0, 1'b0, 1'b0);

        // test 5: early strobe while PEND
        wait_slot(0);
        cpu_access(1'b1, 11'h0A1, 8'h5C, 1'b0, 1'b0, 1'b1);
        cpu_access(1'b0, 11'h0A1, 8'h00, 1'b0, 1'b0, 1'b0);

        // test 6: reset while in RDAT
        wait_slot(1);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_AD = 11'h0A2;
        step();
        RESET_N = 1'b0;
        #1;
        check("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_cpu_wait", 32'(CPU_WAIT), 32'd0);
        check("t6_cpu_ack", 32'(CPU_ACK), 32'd0);
        check("t6_cpu_rd", 32'(CPU_RD), 32'd0);
        check("t6_vid_dt", 32'(VID_DT), 32'd0);
        check("t6_ram_we", 32'(RAM_WE), 32'd0);
        check("t6_ram_be", 32'(RAM_BE), 32'd0);
        check("t6_ram_ad", 32'(RAM_AD), 32'd0);
        check("t6_ram_wd", 32'(RAM_WD), 32'd0);
        CPU_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_ack", 32'(CPU_ACK), 32'd0);
        end
        RESET_N = 1'b1;
        repeat (3) step();
        cpu_access(1'b0, 11'h0A2, 8'h00, 1'b0, 1'b0, 1'b0);

        // randomized traffic, video fetching from a region the CPU never writes
        rand_vid = 1'b1;
        for (int t = 0; t < 80; t++) begin
            bit we, hold, drop;
            int gap;
            we   = 1'($urandom_range(0, 1));
            hold = (t != 79) && ($urandom_range(0, 3) == 0);
            drop = !hold && ($urandom_range(0, 2) == 0);
            cpu_access(we, 11'($urandom_range(0, 11'h5FF)), 8'($urandom_range(0, 255)),
                       hold, drop, 1'b0);
            if (!hold) begin
                gap = $urandom_range(0, 3);
                repeat (gap) step();
            end
        end

        repeat (8) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
